// File: rtl/cron_pkg.sv
// cron_pkg: shared chronometer state encoding and 7-segment code table
package cron_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
endpackage

// File: rtl/debounce_btn.sv
// debounce_btn: synchronises an active-low key and emits one pulse per accepted press
module debounce_btn #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES);
  logic s1, s2, lvl;
  logic [CW-1:0] cnt;
  // lvl only follows s2 after it has disagreed for DB_CYCLES consecutive cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      lvl <= 1'b1;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      press <= 1'b0;
      if (s2 == lvl) cnt <= '0;
      else if (cnt == CW'(DB_CYCLES - 1)) begin
        lvl <= s2;
        cnt <= '0;
        press <= !s2;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/birler_sec.sv
// birler_sec: units-of-seconds stage with run control, 7-segment digit and carry clock
module birler_sec import cron_pkg::*; #(
  parameter int DIV       = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_SS,
  input  logic BTN_CLR,
  output logic CLK_OUT,
  output logic RST_OUT,
  output logic RUNNING,
  output logic ADS,
  output logic BDS,
  output logic CDS,
  output logic DDS,
  output logic EDS,
  output logic FDS,
  output logic GDS
);
  localparam int PW = $clog2(DIV);
  state_t state, state_n;
  logic ss, clr, clr_q, tick;
  logic [PW-1:0] pre;
  logic [3:0] digit;
  seg_t seg;
  debounce_btn #(.DB_CYCLES(DB_CYCLES)) u_ss (.clk(CLK), .rst(RST), .btn(BTN_SS), .press(ss));
  debounce_btn #(.DB_CYCLES(DB_CYCLES)) u_clr (.clk(CLK), .rst(RST), .btn(BTN_CLR), .press(clr));
  assign tick = state == RUN && pre == PW'(DIV - 1);
  always_comb state_n = clr ? IDLE : !ss ? state : state == RUN ? PAUSE : RUN;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_n;
  // clear outranks a coincident tick, so the carry can never rise on a clear
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      pre <= '0;
      digit <= '0;
      CLK_OUT <= 1'b0;
      clr_q <= 1'b0;
      RUNNING <= 1'b0;
      seg <= SEG_DIGIT[0];
    end else begin
      pre <= (clr || state == IDLE) ? '0 : state != RUN ? pre : tick ? '0 : pre + 1'b1;
      digit <= clr ? 4'd0 : !tick ? digit : digit == 4'd9 ? 4'd0 : digit + 1'b1;
      CLK_OUT <= clr ? 1'b0 : (tick && digit == 4'd9) ? 1'b1 : (tick && digit == 4'd4) ? 1'b0 : CLK_OUT;
      clr_q <= clr;
      RUNNING <= state_n == RUN;
      seg <= SEG_DIGIT[digit];
    end
  assign RST_OUT = RST | clr_q;
  assign {GDS, FDS, EDS, DDS, CDS, BDS, ADS} = seg;
endmodule

// File: tb/tb_birler_sec.sv
// tb_birler_sec: randomized key stimulus checked against a cycle-level behavioural model
module tb_birler_sec;
  localparam int DIV = 4, DB = 3, MAXC = 16384;
  localparam int IDLE = 0, RUN = 1, PAUSE = 2;
  logic clk = 0, rst = 1, btn_ss = 1, btn_clr = 1;
  logic clk_out, rst_out, running, ads, bds, cds, dds, eds, fds, gds;
  int tests = 0, fails = 0, cyc = 0;
  bit raw_ss [MAXC];
  bit raw_clr [MAXC];
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int m_state, m_pre, m_digit, m_prev, m_carry, m_clrq;
  bit lvl_ss, lvl_clr, pend_ss, pend_clr;

  birler_sec #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .CLK(clk), .RST(rst), .BTN_SS(btn_ss), .BTN_CLR(btn_clr),
    .CLK_OUT(clk_out), .RST_OUT(rst_out), .RUNNING(running),
    .ADS(ads), .BDS(bds), .CDS(cds), .DDS(dds), .EDS(eds), .FDS(fds), .GDS(gds)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // a key level is accepted once the synchronised samples agree for DB cycles
  function automatic bit window(input bit is_clr, input bit v, input int n);
    bit r;
    for (int k = n - 2 - DB; k <= n - 3; k++) begin
      r = (k < 0) ? 1'b1 : (is_clr ? raw_clr[k] : raw_ss[k]);
      if (r != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset;
    m_state = IDLE; m_pre = 0; m_digit = 0; m_prev = 0; m_carry = 0; m_clrq = 0;
    lvl_ss = 1; lvl_clr = 1; pend_ss = 0; pend_clr = 0;
  endtask

  task automatic model_edge(input int n);
    bit ss_now, clr_now, tk;
    ss_now = 0; clr_now = 0;
    if (window(1'b0, !lvl_ss, n)) begin lvl_ss = !lvl_ss; ss_now = !lvl_ss; end
    if (window(1'b1, !lvl_clr, n)) begin lvl_clr = !lvl_clr; clr_now = !lvl_clr; end
    m_prev = m_digit;
    m_clrq = pend_clr;
    if (pend_clr) begin
      m_state = IDLE; m_pre = 0; m_digit = 0; m_carry = 0;
    end else begin
      tk = m_state == RUN && m_pre == DIV - 1;
      if (m_state == RUN) m_pre = (m_pre + 1) % DIV;
      else if (m_state == IDLE) m_pre = 0;
      if (tk) begin
        if (m_digit == 9) m_carry = 1;
        if (m_digit == 4) m_carry = 0;
        m_digit = (m_digit + 1) % 10;
      end
      if (pend_ss) m_state = (m_state == RUN) ? PAUSE : RUN;
    end
    pend_ss = ss_now; pend_clr = clr_now;
  endtask

  task automatic step;
    bit r;
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget: got %0d expected < %0d", cyc, MAXC - 1);
      $fatal(1);
    end
    raw_ss[cyc] = btn_ss; raw_clr[cyc] = btn_clr; r = rst;
    @(posedge clk);
    cyc++;
    if (r) model_reset;
    else model_edge(cyc);
    #1;
    check("segs", {1'b0, gds, fds, eds, dds, cds, bds, ads}, {1'b0, seg_tab[m_prev]});
    check("clk_out", {7'b0, clk_out}, 8'(m_carry));
    check("running", {7'b0, running}, {7'b0, m_state == RUN});
    check("rst_out", {7'b0, rst_out}, {7'b0, rst | (m_clrq != 0)});
  endtask

  task automatic press(input bit s, input bit c, input int hold, input int gap);
    if (s) btn_ss = 0;
    if (c) btn_clr = 0;
    repeat (hold) step;
    btn_ss = 1; btn_clr = 1;
    repeat (gap) step;
  endtask

  task automatic bounce;
    for (int i = 0; i < 6; i++) begin btn_ss = ~btn_ss; step; end
    btn_ss = 0;
    repeat (8) step;
    btn_ss = 1;
    repeat (8) step;
  endtask

  task automatic do_reset(input int n);
    btn_ss = 1; btn_clr = 1;
    repeat (8) step;
    rst = 1;
    #1;
    check("async_segs", {1'b0, gds, fds, eds, dds, cds, bds, ads}, 8'h40);
    check("async_clk_out", {7'b0, clk_out}, 8'd0);
    check("async_running", {7'b0, running}, 8'd0);
    check("async_rst_out", {7'b0, rst_out}, 8'd1);
    model_reset;
    repeat (n) step;
    rst = 0;
    repeat (2) step;
  endtask

  initial begin
    int w;
    model_reset;
    repeat (3) step;
    rst = 0;
    repeat (3) step;
    press(1, 0, 10, 8);
    repeat (60) step;
    press(1, 0, 6, 6);
    repeat (20) step;
    press(1, 0, 6, 6);
    repeat (50) step;
    // aim the clear so it lands on the same edge as the 9->0 tick
    w = 0;
    while (!(m_state == RUN && m_digit == 8 && m_pre == 2) && w < 200) begin step; w++; end
    check("clr_align_timeout", 8'(w < 200), 8'd1);
    press(0, 1, 6, 10);
    press(1, 0, 6, 6);
    bounce;
    press(1, 1, 6, 10);
    press(1, 0, 6, 30);
    do_reset(3);
    repeat (60) begin
      case ($urandom_range(0, 10))
        0, 1, 2, 3, 4, 5: press(1, 0, $urandom_range(1, 10), $urandom_range(1, 12));
        6: press(0, 1, $urandom_range(1, 10), $urandom_range(1, 12));
        7: press(1, 1, $urandom_range(2, 8), $urandom_range(4, 12));
        8: repeat ($urandom_range(1, 60)) step;
        9: bounce;
        default: do_reset($urandom_range(1, 4));
      endcase
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
